// File: rtl/busy_req_queue_pkg.sv
// Shared definitions for the busy request queue: FSM state encoding and counter width helper.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package busy_pkg;

    // Queue FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;   // nothing pending, o_start low
    localparam state_t ST_REQ  = 2'd1;   // presenting a job, o_start held high
    localparam state_t ST_GAP  = 2'd2;   // enforced idle gap after an accept

    // Bits needed to hold values 0..max_val, never less than one bit so that a
    // zero-valued parameter (e.g. GAP_CYCLES=0) still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/busy_req_gap_timer.sv
// Loadable down-counter with a zero flag; stops at zero.
// Latency: load/decrement visible one cycle after the edge.
// Backpressure: none; load has priority over dec.
// Ports: i_clk, i_reset_n (async active-low), load/load_val, dec, zero.
module busy_req_gap_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/busy_req_queue.sv
// Collects request pulses into a saturating pending count and presents them one at a time as a held start.
// Latency: o_start rises one cycle after the first i_req; GAP_CYCLES low cycles after each accept.
// Backpressure: o_start is held until accepted (o_start && !i_busy); requests arriving while full are dropped.
// Ports: i_clk, i_reset_n (async active-low), i_req, i_busy -> o_start, o_pending, o_full,
//        o_overflow (sticky drop flag), o_timeout (sticky watchdog flag).
// Optional macro BUSY_REQ_QUEUE_TIMEOUT_EN adds a watchdog on o_start held for TIMEOUT cycles;
// without it o_timeout is tied low.
module busy_req_queue
    import busy_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_req,
    input  logic                       i_busy,
    output logic                       o_start,
    output logic [$clog2(DEPTH+1)-1:0] o_pending,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic                       o_timeout
);

    localparam int            PW       = $clog2(DEPTH + 1);
    localparam int            GW       = cnt_width(GAP_CYCLES);
    localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state_q, state_nx;
    logic [PW-1:0] count_q, count_nx;
    logic          full_q;
    logic          ovf_q;
    logic          accept;
    logic          take_req;
    logic          gap_zero;
    logic          gap_load;
    logic          gap_dec;

    assign accept   = (state_q == ST_REQ) && !i_busy;
    // An accept on the same edge frees a slot, so a coincident request is never dropped.
    assign take_req = i_req && (!full_q || accept);

    always_comb begin
        count_nx = count_q;
        if (take_req && !accept) begin
            count_nx = count_q + ONE;
        end else if (!take_req && accept) begin
            count_nx = count_q - ONE;
        end
    end

    always_comb begin
        state_nx = state_q;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_nx != '0) state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (accept) begin
                    if (GAP_CYCLES > 0) begin
                        state_nx = ST_GAP;
                        gap_load = 1'b1;
                    end else if (count_nx == '0) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_nx = (count_nx != '0) ? ST_REQ : ST_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            count_q <= count_nx;
            full_q  <= (count_nx == DEPTH_V);
            if (i_req && !take_req) ovf_q <= 1'b1;
        end
    end

    busy_req_gap_timer #(.W(GW)) u_gap_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .load      (gap_load),
        .load_val  (GAP_LOAD),
        .dec       (gap_dec),
        .zero      (gap_zero)
    );

    // o_start is a pure decode of the registered state, never a path from i_busy.
    assign o_start    = (state_q == ST_REQ);
    assign o_pending  = count_q;
    assign o_full     = full_q;
    assign o_overflow = ovf_q;

`ifdef BUSY_REQ_QUEUE_TIMEOUT_EN
    localparam int            WW      = cnt_width(TIMEOUT);
    localparam logic [WW-1:0] WD_LOAD = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic wd_run;
    logic wd_zero;
    logic tmo_q;

    // Reloaded whenever o_start is not being held unaccepted; the flag sets on the
    // TIMEOUT-th consecutive unaccepted REQ edge. The request itself is never withdrawn.
    assign wd_run = (state_q == ST_REQ) && !accept;

    busy_req_gap_timer #(.W(WW)) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .load      (!wd_run),
        .load_val  (WD_LOAD),
        .dec       (wd_run),
        .zero      (wd_zero)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_q <= 1'b0;
        end else if (wd_run && wd_zero) begin
            tmo_q <= 1'b1;
        end
    end

    assign o_timeout = tmo_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign o_timeout = 1'b0;
`endif

endmodule
